serial_tx_arbiter: RTL
======================

SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- Width, 8, data byte width, matching the serial transmitter.
- Requesters, 4, number of requester ports, 2..8.
- WatchdogCycles, 4, maximum cycles to wait for tx_busy to rise after a launch.

REQ-002 The block SHALL have these ports (clock and reset first):
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  Requesters  per-requester byte request, level, held until ack.
- req_last  in  Requesters  per-requester marker that the offered byte ends its frame.
- req_data  in  Requesters*Width  packed bytes; requester i occupies bits [i*Width +: Width].
- ack  out  Requesters  one-hot one-cycle pulse; the byte was taken.
- tx_ce  out  1  launch strobe to the transmitter.
- tx_d  out  Width  byte to the transmitter.
- tx_busy  in  1  transmitter busy flag.
- grant_valid  out  1  a requester currently owns the transmitter (frame open or byte in flight).
- grant_idx  out  clog2(Requesters)  index of the current owner.
- err  out  1  sticky watchdog error.

Function
REQ-003 The block SHALL implement exactly four states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.

REQ-004 In IDLE, when tx_busy=0 and an eligible req is high, the block SHALL register the winner index and its req_data/req_last, then move to LAUNCH.
- Arbitration latency is 1 cycle from req to LAUNCH.

REQ-005 In LAUNCH, tx_ce=1 and ack[winner]=1 SHALL be asserted for exactly one cycle, with tx_d holding the registered byte; the next state is WAIT_BUSY.

REQ-006 In WAIT_BUSY, the block SHALL go to WAIT_DONE on tx_busy=1.
- If tx_busy stays 0 for WatchdogCycles cycles, it SHALL set err=1, release any frame lock, and return to IDLE.

REQ-007 In WAIT_DONE, the block SHALL return to IDLE on tx_busy=0.
- No new tx_ce is issued while tx_busy=1.

REQ-008 With no frame lock, eligibility SHALL be round-robin: the search starts at index ptr, wraps modulo Requesters, and the first high req wins.

REQ-009 When a byte with req_last=0 is launched, a frame lock SHALL be set to that requester.
- While locked, only the owner is eligible and other requests are ignored.
- If the owner drops req while locked, the block SHALL wait in IDLE indefinitely with the lock held.

REQ-010 When a byte with req_last=1 is launched, the lock SHALL clear and ptr SHALL become (winner+1) mod Requesters.
- ptr is unchanged by bytes with req_last=0.

REQ-011 grant_valid SHALL be 1 from LAUNCH through WAIT_DONE, and in IDLE while a lock is held; grant_idx holds the owner index whenever grant_valid=1.

REQ-012 tx_d SHALL keep its last launched value outside LAUNCH; ack SHALL be 0 outside LAUNCH.

REQ-013 tx_busy=1 in IDLE SHALL block arbitration; the lock and ptr are unchanged.

REQ-014 A req change during LAUNCH, WAIT_BUSY or WAIT_DONE SHALL not affect the byte in flight.

Reset
REQ-015 On rst=1 at a clock edge, the block SHALL force:
- state=IDLE, ptr=0, lock clear, watchdog counter=0;
- tx_ce=0, tx_d=0, ack=0, grant_valid=0, grant_idx=0, err=0.

REQ-016 rst SHALL take priority over every other event.
- A reset during LAUNCH drops that byte: neither ack nor tx_ce is asserted in that cycle.
- A reset during WAIT_BUSY or WAIT_DONE abandons the in-flight byte without waiting for tx_busy.

REQ-017 err SHALL clear only on rst.

Structure
REQ-018 A shared package serial_arb_pkg SHALL hold the state enumeration (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE) and the default Width/Requesters/WatchdogCycles constants.

REQ-019 The round-robin search SHALL be a combinational sub-module rr_picker.
- Inputs: req vector and ptr.
- Outputs: found flag and index.

REQ-020 The FSM, lock, ptr, watchdog counter and output registers SHALL live in serial_tx_arbiter.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Single request: req[2]=1, data 0xA5, last=1 -> one tx_ce with tx_d=0xA5 and ack[2] in the same cycle; ptr becomes 3.
- Round-robin: req=4'b1111 held, all last=1, ptr=0 -> grant order 0,1,2,3,0, with one launch per transmitter busy period.
- Frame lock: req0 sends 0x11 (last=0), then 0x22 (last=1) while req1 is high throughout -> both req0 bytes are sent before any req1 byte.
- Watchdog: tx_busy tied 0 after a launch -> err=1 after 4 cycles in WAIT_BUSY; the FSM returns to IDLE and the lock is cleared.
- Reset mid-frame: rst in WAIT_DONE with a lock held -> next cycle IDLE, grant_valid=0, ptr=0, tx_ce=0.
- Busy blocking: tx_busy=1 in IDLE with req[1]=1 -> no tx_ce until tx_busy=0, then launch within 2 cycles.

Source files
------------

// File: rtl/serial_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_arb_pkg
// Description : Shared state encoding and default sizing for the serial
//               transmitter arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_arb_pkg;

    localparam int c_def_width           = 8;
    localparam int c_def_requesters      = 4;
    localparam int c_def_watchdog_cycles = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

endpackage : serial_arb_pkg
`default_nettype wire

// File: rtl/serial_tx_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin search. Starts at ptr_i, wraps
//               modulo Requesters, reports the first asserted request.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import serial_arb_pkg::*;
#(
    parameter int Requesters = c_def_requesters
) (
    input  logic [Requesters-1:0]         req_i,
    input  logic [$clog2(Requesters)-1:0] ptr_i,
    output logic                          found_o,
    output logic [$clog2(Requesters)-1:0] idx_o
);

    localparam int c_idx_w = $clog2(Requesters);

    // Walk offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = Requesters - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % Requesters]) begin
                found_o = 1'b1;
                idx_o   = c_idx_w'((int'(ptr_i) + k) % Requesters);
            end
        end
    end

endmodule : rr_picker
`default_nettype wire

// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : serial_tx_arbiter
// Description : Arbitrates byte requests from several requesters onto one
//               serial transmitter, with frame locking, round-robin fairness
//               and a watchdog on the transmitter's busy handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_tx_arbiter
    import serial_arb_pkg::*;
#(
    parameter int Width          = c_def_width,
    parameter int Requesters     = c_def_requesters,
    parameter int WatchdogCycles = c_def_watchdog_cycles
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [Requesters-1:0]         req,
    input  logic [Requesters-1:0]         req_last,
    input  logic [Requesters*Width-1:0]   req_data,
    output logic [Requesters-1:0]         ack,
    output logic                          tx_ce,
    output logic [Width-1:0]              tx_d,
    input  logic                          tx_busy,
    output logic                          grant_valid,
    output logic [$clog2(Requesters)-1:0] grant_idx,
    output logic                          err
);

    localparam int                 c_idx_w    = $clog2(Requesters);
    localparam int                 c_wd_w     = (WatchdogCycles > 1) ? $clog2(WatchdogCycles) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(Requesters - 1);
    localparam logic [c_wd_w-1:0]  c_wd_last  = c_wd_w'(WatchdogCycles - 1);

    // Registered state. r_grant_idx_q doubles as the lock owner.
    arb_state_t             r_state_q;
    logic [c_idx_w-1:0]     r_ptr_q;
    logic                   r_lock_q;
    logic                   r_last_q;
    logic [c_wd_w-1:0]      r_wd_cnt_q;
    logic [Requesters-1:0]  r_ack_q;
    logic                   r_tx_ce_q;
    logic [Width-1:0]       r_tx_d_q;
    logic                   r_grant_valid_q;
    logic [c_idx_w-1:0]     r_grant_idx_q;
    logic                   r_err_q;

    // Arbitration datapath.
    logic [Requesters-1:0]  w_owner_mask;
    logic [Requesters-1:0]  w_elig;
    logic [c_idx_w-1:0]     w_pick_ptr;
    logic                   w_found;
    logic [c_idx_w-1:0]     w_pick_idx;
    logic [Requesters-1:0]  w_win_mask;
    logic [Width-1:0]       w_win_data;
    logic                   w_win_last;
    logic [c_idx_w-1:0]     w_ptr_d;

    // While a frame is locked only the owner may compete; the picker then
    // starts at the owner so the result is the owner or nothing.
    assign w_owner_mask = Requesters'(1) << r_grant_idx_q;
    assign w_elig       = r_lock_q ? (req & w_owner_mask) : req;
    assign w_pick_ptr   = r_lock_q ? r_grant_idx_q : r_ptr_q;

    rr_picker #(
        .Requesters (Requesters)
    ) u_rr_picker (
        .req_i   (w_elig),
        .ptr_i   (w_pick_ptr),
        .found_o (w_found),
        .idx_o   (w_pick_idx)
    );

    assign w_win_mask = Requesters'(1) << w_pick_idx;
    assign w_win_data = req_data[int'(w_pick_idx) * Width +: Width];
    assign w_win_last = req_last[w_pick_idx];
    assign w_ptr_d    = (r_grant_idx_q == c_last_idx) ? '0 : r_grant_idx_q + c_idx_w'(1);

    // Arbiter FSM with lock, pointer, watchdog and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q       <= IDLE;
            r_ptr_q         <= '0;
            r_lock_q        <= 1'b0;
            r_last_q        <= 1'b0;
            r_wd_cnt_q      <= '0;
            r_ack_q         <= '0;
            r_tx_ce_q       <= 1'b0;
            r_tx_d_q        <= '0;
            r_grant_valid_q <= 1'b0;
            r_grant_idx_q   <= '0;
            r_err_q         <= 1'b0;
        end else begin
            case (r_state_q)
                IDLE: begin
                    if (!tx_busy && w_found) begin
                        r_grant_idx_q   <= w_pick_idx;
                        r_last_q        <= w_win_last;
                        r_tx_d_q        <= w_win_data;
                        r_tx_ce_q       <= 1'b1;
                        r_ack_q         <= w_win_mask;
                        r_grant_valid_q <= 1'b1;
                        r_state_q       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_tx_ce_q  <= 1'b0;
                    r_ack_q    <= '0;
                    r_wd_cnt_q <= '0;
                    r_state_q  <= WAIT_BUSY;
                    if (r_last_q) begin
                        r_lock_q <= 1'b0;
                        r_ptr_q  <= w_ptr_d;
                    end else begin
                        r_lock_q <= 1'b1;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_wd_cnt_q <= '0;
                        r_state_q  <= WAIT_DONE;
                    end else if (r_wd_cnt_q == c_wd_last) begin
                        // Transmitter never acknowledged: flag it and drop the frame.
                        r_err_q         <= 1'b1;
                        r_lock_q        <= 1'b0;
                        r_grant_valid_q <= 1'b0;
                        r_wd_cnt_q      <= '0;
                        r_state_q       <= IDLE;
                    end else begin
                        r_wd_cnt_q <= r_wd_cnt_q + c_wd_w'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_grant_valid_q <= r_lock_q;
                        r_state_q       <= IDLE;
                    end
                end
                default: begin
                    r_state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack         = r_ack_q;
    assign tx_ce       = r_tx_ce_q;
    assign tx_d        = r_tx_d_q;
    assign grant_valid = r_grant_valid_q;
    assign grant_idx   = r_grant_idx_q;
    assign err         = r_err_q;

endmodule : serial_tx_arbiter
`default_nettype wire
